program_counter: RTL and testbench
==================================

Name: program_counter

Overview:
- Architectural program counter register for the single-cycle RV32I core.
- Captures the next-PC value computed by the fetch/branch logic on every rising clock edge and presents it as the current fetch address.
- Sits between the next-PC mux (input) and the instruction memory, PC+4 adder and branch target adder (outputs).

Parameters:
- XLEN, 32, width of the PC in bits.
- RESET_VECTOR, 32'h0000_0000, value loaded into the PC while reset is asserted.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- next_pc  input  XLEN  address to load on the next rising edge.
- pc_out  output  XLEN  current PC value (registered).
- pc_misaligned  output  1  high when pc_out[1:0] != 2'b00.

Behaviour:
- Single register of XLEN bits, updated only on the rising edge of clk.
- Reset (synchronous, active-high):
  - At each rising edge with reset=1, the register becomes RESET_VECTOR.
  - next_pc is ignored during reset.
  - Reset has priority over every other condition, including stall when PC_STALL_EN is compiled in.
  - Reset asserted mid-run takes effect on the first rising edge it is sampled high, with no further delay.
- Normal load: at each rising edge with reset=0, the register becomes next_pc.
  - Latency is exactly one cycle: a value driven before edge N is visible on pc_out after edge N.
- next_pc is stored unmodified.
  - No alignment masking and no increment inside the block.
  - PC+4 is computed externally.
- pc_out is driven directly from the register, with no combinational path from next_pc.
- pc_misaligned is combinational from the register: OR of pc_out[1:0]. It is 0 after reset when RESET_VECTOR is word aligned.
- Width rules: no arithmetic. Values at the top of the address space (e.g. 32'hFFFF_FFFC) load unchanged, with no wrap or saturation concerns.
- Power-up, before the first reset edge: register value undefined. Verification must not check pc_out before the first reset edge.
- Holding reset high for several cycles keeps pc_out at RESET_VECTOR throughout.
- Deasserting reset in the same cycle next_pc is driven: the first edge with reset=0 loads that next_pc.

Optional Feature:
- Macro: PC_STALL_EN.
- When defined:
  - Adds input port stall (1 bit), placed after next_pc.
  - At a rising edge with reset=0 and stall=1, the register holds its current value and next_pc is ignored.
  - stall=0 loads normally.
  - reset=1 overrides stall.
- When not defined:
  - No stall port exists.
  - The register loads next_pc on every non-reset edge.

Decomposition:
- Shared package rv32i_pkg holds:
  - XLEN (32),
  - RESET_VECTOR (32'h0000_0000),
  - typedef addr_t (logic [XLEN-1:0]).
- The module parameters default to these package constants.
- No sub-module: a single flop bank plus the misalignment OR.

Test Plan:
- Reset then load: reset=1 for one edge, next_pc=0 → pc_out=0x00000000. Then reset=0 with next_pc=0x00000004, 0x00000008, 0x0000000C on successive edges → pc_out follows each one edge later; pc_misaligned=0 throughout.
- Mid-run reset: with pc_out=0x0000000C, assert reset for one edge with next_pc=0x0000000C still applied → pc_out=0x00000000. Deassert, next_pc=0x00000020 → pc_out=0x00000020 after the next edge.
- Synchronous check: toggle reset high and low between clock edges without crossing an edge → pc_out unchanged. Also hold reset high for 3 edges with next_pc=0x12345678 → pc_out stays 0x00000000.
- Full-range and misaligned: next_pc=0xFFFFFFFC → pc_out=0xFFFFFFFC, pc_misaligned=0. Then next_pc=0x00000006 → pc_out=0x00000006, pc_misaligned=1.
- Latency: change next_pc just after an edge → pc_out does not change until the following rising edge.
- PC_STALL_EN build:
  - pc_out=0x00000010, stall=1, next_pc=0x00000014 for 2 edges → pc_out stays 0x00000010.
  - stall=0 → 0x00000014 after the next edge.
  - stall=1 with reset=1 → pc_out=0x00000000.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I core constants and address type.
package rv32i_pkg;

    localparam int XLEN = 32;

    typedef logic [XLEN-1:0] addr_t;

    localparam addr_t RESET_VECTOR = 32'h0000_0000;

endpackage

// File: rtl/program_counter.sv
// Architectural PC register for the single-cycle RV32I core.
// Optional hold input enabled by defining PC_STALL_EN.
module program_counter
    import rv32i_pkg::*;
#(
    parameter int XLEN = rv32i_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(rv32i_pkg::RESET_VECTOR)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] next_pc,
`ifdef PC_STALL_EN
    input  logic            stall,
`endif
    output logic [XLEN-1:0] pc_out,
    output logic            pc_misaligned
);

    logic [XLEN-1:0] pc_q;

`ifdef PC_STALL_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_VECTOR;
        end else if (!stall) begin
            pc_q <= next_pc;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_VECTOR;
        end else begin
            pc_q <= next_pc;
        end
    end
`endif

    assign pc_out        = pc_q;
    assign pc_misaligned = |pc_q[1:0];

endmodule

// File: tb/tb_program_counter.sv
// Directed self-checking bench for program_counter.
// Stall sequence is exercised only when PC_STALL_EN is defined.
module tb_program_counter;

    logic        clk;
    logic        reset;
    logic [31:0] next_pc;
`ifdef PC_STALL_EN
    logic        stall;
`endif
    logic [31:0] pc_out;
    logic        pc_misaligned;

    int checks;
    int passed;

    typedef struct {
        logic        rst;
        logic [31:0] npc;
        logic [31:0] exp_pc;
        logic        exp_mis;
    } vec_t;

    vec_t vecs[11];

    program_counter dut (
        .clk          (clk),
        .reset        (reset),
        .next_pc      (next_pc),
`ifdef PC_STALL_EN
        .stall        (stall),
`endif
        .pc_out       (pc_out),
        .pc_misaligned(pc_misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_pc(input string name, input logic [31:0] exp_pc,
                            input logic exp_mis);
        checks++;
        if (pc_out === exp_pc) begin
            passed++;
        end else begin
            $display("FAIL %s pc_out: got %h expected %h", name, pc_out, exp_pc);
        end
        checks++;
        if (pc_misaligned === exp_mis) begin
            passed++;
        end else begin
            $display("FAIL %s pc_misaligned: got %b expected %b",
                     name, pc_misaligned, exp_mis);
        end
    endtask

    task automatic edge_step(input logic rst, input logic [31:0] npc);
        @(negedge clk);
        reset   = rst;
        next_pc = npc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks  = 0;
        passed  = 0;
        reset   = 1'b0;
        next_pc = 32'h0;
`ifdef PC_STALL_EN
        stall   = 1'b0;
`endif

        vecs[0]  = '{1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[1]  = '{1'b0, 32'h0000_0004, 32'h0000_0004, 1'b0};
        vecs[2]  = '{1'b0, 32'h0000_0008, 32'h0000_0008, 1'b0};
        vecs[3]  = '{1'b0, 32'h0000_000C, 32'h0000_000C, 1'b0};
        vecs[4]  = '{1'b1, 32'h0000_000C, 32'h0000_0000, 1'b0};
        vecs[5]  = '{1'b0, 32'h0000_0020, 32'h0000_0020, 1'b0};
        vecs[6]  = '{1'b1, 32'h1234_5678, 32'h0000_0000, 1'b0};
        vecs[7]  = '{1'b1, 32'h1234_5678, 32'h0000_0000, 1'b0};
        vecs[8]  = '{1'b1, 32'h1234_5678, 32'h0000_0000, 1'b0};
        vecs[9]  = '{1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0};
        vecs[10] = '{1'b0, 32'h0000_0006, 32'h0000_0006, 1'b1};

        for (int i = 0; i < 11; i++) begin
            edge_step(vecs[i].rst, vecs[i].npc);
            check_pc($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_mis);
        end

        // Reset pulse between edges must not be sampled.
        @(negedge clk);
        next_pc = 32'h0000_0040;
        reset   = 1'b1;
        #1;
        check_pc("async_pulse_now", 32'h0000_0006, 1'b1);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check_pc("async_pulse_edge", 32'h0000_0040, 1'b0);

        // Input change just after an edge waits for the next edge.
        next_pc = 32'h0000_0080;
        #2;
        check_pc("latency_hold", 32'h0000_0040, 1'b0);
        @(posedge clk);
        #1;
        check_pc("latency_load", 32'h0000_0080, 1'b0);

`ifdef PC_STALL_EN
        edge_step(1'b0, 32'h0000_0010);
        check_pc("stall_setup", 32'h0000_0010, 1'b0);
        @(negedge clk);
        stall   = 1'b1;
        next_pc = 32'h0000_0014;
        @(posedge clk);
        #1;
        check_pc("stall_hold1", 32'h0000_0010, 1'b0);
        @(posedge clk);
        #1;
        check_pc("stall_hold2", 32'h0000_0010, 1'b0);
        @(negedge clk);
        stall = 1'b0;
        @(posedge clk);
        #1;
        check_pc("stall_release", 32'h0000_0014, 1'b0);
        @(negedge clk);
        stall = 1'b1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_pc("stall_reset", 32'h0000_0000, 1'b0);
        @(negedge clk);
        stall = 1'b0;
        reset = 1'b0;
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
